// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding and bus-level constants.
package i2c_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StDev,
        StDevAck,
        StPtr,
        StPtrAck,
        StWr,
        StWrAck,
        StRd,
        StRdAck,
        StIgnore
    } i2c_target_state_t;

    localparam logic        AckLevel    = 1'b0;
    localparam int unsigned RwBit       = 0;
    localparam logic [6:0]  GenCallAddr = 7'h00;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus run-length glitch filter for one I2C line, with registered
// rise/fall pulses aligned to the cycle the filtered level changes.
module i2c_line_filter #(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic clk_i,
    input  logic srst_i,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic            rise_q, fall_q;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Level flips only after FILTER_LEN consecutive samples disagree with it.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CntW'(FILTER_LEN - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // Idle bus level is high, so reset to 1 to avoid a spurious edge.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= level_d & ~level_q;
            fall_q  <= ~level_d & level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target with register-file strobe port. Define I2C_TARGET_AUTOINC_EN to auto-increment
// the register pointer across consecutive words on writes and acknowledged reads.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR   = 7'h0A,
    parameter int unsigned ADDR_BYTES = 2,
    parameter int unsigned DATA_BYTES = 2,
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic                    clk_i,
    input  logic                    srst_i,
    input  logic                    scl_i,
    input  logic                    sda_i,
    output logic                    sda_oe_o,
    output logic [8*ADDR_BYTES-1:0] reg_addr_o,
    output logic [8*DATA_BYTES-1:0] reg_wdata_o,
    output logic                    reg_we_o,
    output logic                    reg_re_o,
    input  logic [8*DATA_BYTES-1:0] reg_rdata_i,
    output logic                    busy_o
);

    localparam int unsigned AddrW    = 8 * ADDR_BYTES;
    localparam int unsigned DataW    = 8 * DATA_BYTES;
    localparam logic [1:0]  LastPtr  = 2'(ADDR_BYTES - 1);
    localparam logic [1:0]  LastData = 2'(DATA_BYTES - 1);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_c, stop_c;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk_i  (clk_i),
        .srst_i (srst_i),
        .line_i (scl_i),
        .level_o(scl_lvl),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk_i  (clk_i),
        .srst_i (srst_i),
        .line_i (sda_i),
        .level_o(sda_lvl),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    assign start_c = sda_fall & scl_lvl;
    assign stop_c  = sda_rise & scl_lvl;

    i2c_target_state_t state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [AddrW-1:0] ptr_q, ptr_d;
    logic [AddrW-1:0] addr_q, addr_d;
    logic [DataW-1:0] wdata_q, wdata_d;
    logic [DataW-1:0] tx_q, tx_d;
    logic [1:0]       re_dly_q, re_dly_d;
    logic             rw_q, rw_d;
    logic             ack_q, ack_d;
    logic             wr_full_q, wr_full_d;
    logic             sda_oe_q, sda_oe_d;
    logic             we_q, we_d;
    logic             re_q, re_d;
    logic             busy_q, busy_d;

    logic [7:0]       new_byte;
    logic [AddrW-1:0] ptr_next;
    logic [DataW-1:0] wdata_next;

    assign new_byte   = {shift_q[6:0], sda_lvl};
    assign ptr_next   = (ptr_q << 8) | AddrW'(shift_q);
    assign wdata_next = (wdata_q << 8) | DataW'(new_byte);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        tx_d       = tx_q;
        re_dly_d   = {re_dly_q[0], re_q};
        rw_d       = rw_q;
        ack_d      = ack_q;
        wr_full_d  = wr_full_q;
        sda_oe_d   = sda_oe_q;
        we_d       = 1'b0;
        re_d       = 1'b0;
        busy_d     = busy_q;

        unique case (state_q)
            StIdle, StIgnore: ;
            StDev: begin
                if (scl_rise) begin
                    shift_d   = new_byte;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end else if (scl_fall && bit_cnt_q == 4'd8) begin
                    bit_cnt_d = '0;
                    rw_d      = shift_q[RwBit];
                    if (shift_q[7:1] == DEV_ADDR && shift_q[7:1] != GenCallAddr) begin
                        state_d  = StDevAck;
                        sda_oe_d = 1'b1;
                    end else begin
                        state_d = StIgnore;
                    end
                end
            end
            StDevAck: begin
                if (scl_fall) begin
                    sda_oe_d   = 1'b0;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    if (rw_q) begin
                        state_d = StRd;
                        re_d    = 1'b1;
                    end else begin
                        state_d = StPtr;
                    end
                end
            end
            StPtr: begin
                if (scl_rise) begin
                    shift_d   = new_byte;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end else if (scl_fall && bit_cnt_q == 4'd8) begin
                    bit_cnt_d = '0;
                    ptr_d     = ptr_next;
                    // Pointer only becomes visible once all its bytes have arrived.
                    if (byte_cnt_q == LastPtr) begin
                        addr_d = ptr_next;
                    end
                    state_d  = StPtrAck;
                    sda_oe_d = 1'b1;
                end
            end
            StPtrAck: begin
                if (scl_fall) begin
                    sda_oe_d = 1'b0;
                    if (byte_cnt_q == LastPtr) begin
                        state_d    = StWr;
                        byte_cnt_d = '0;
                        wr_full_d  = 1'b0;
                    end else begin
                        state_d    = StPtr;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            StWr: begin
                if (scl_rise) begin
                    shift_d   = new_byte;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        ack_d = ~wr_full_q;
                        if (!wr_full_q) begin
                            wdata_d = wdata_next;
                            if (byte_cnt_q == LastData) begin
                                we_d       = 1'b1;
                                byte_cnt_d = '0;
`ifndef I2C_TARGET_AUTOINC_EN
                                wr_full_d  = 1'b1;
`endif
                            end else begin
                                byte_cnt_d = byte_cnt_q + 2'd1;
                            end
                        end
                    end
                end else if (scl_fall && bit_cnt_q == 4'd8) begin
                    bit_cnt_d = '0;
                    state_d   = StWrAck;
                    sda_oe_d  = ack_q;
                end
            end
            StWrAck: begin
                if (scl_fall) begin
                    sda_oe_d = 1'b0;
                    state_d  = StWr;
                end
            end
            StRd: begin
                // Read data lands a few cycles after the ACK fall, so the first bit is driven
                // on load rather than on a falling edge; SCL is still low at that point.
                if (re_dly_q[1]) begin
                    tx_d      = reg_rdata_i;
                    sda_oe_d  = ~reg_rdata_i[DataW-1];
                    bit_cnt_d = '0;
                end else if (scl_fall) begin
                    tx_d      = {tx_q[DataW-2:0], 1'b1};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = StRdAck;
                    end else begin
                        sda_oe_d = ~tx_q[DataW-2];
                    end
                end
            end
            StRdAck: begin
                if (scl_rise) begin
                    ack_d = (sda_lvl == AckLevel);
                end else if (scl_fall) begin
                    if (!ack_q) begin
                        state_d = StIgnore;
                    end else begin
                        state_d   = StRd;
                        bit_cnt_d = '0;
                        if (byte_cnt_q != LastData) begin
                            byte_cnt_d = byte_cnt_q + 2'd1;
                            sda_oe_d   = ~tx_q[DataW-1];
                        end else begin
`ifdef I2C_TARGET_AUTOINC_EN
                            addr_d     = addr_q + AddrW'(1);
                            re_d       = 1'b1;
                            byte_cnt_d = '0;
`else
                            // Shift register is backfilled with ones: bus reads 0xFF.
                            sda_oe_d   = ~tx_q[DataW-1];
`endif
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef I2C_TARGET_AUTOINC_EN
        if (we_q) begin
            addr_d = addr_q + AddrW'(1);
        end
`endif

        if (stop_c) begin
            state_d    = StIdle;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
            we_d       = 1'b0;
            re_d       = 1'b0;
            re_dly_d   = '0;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
        end else if (start_c) begin
            state_d    = StDev;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b1;
            we_d       = 1'b0;
            re_d       = 1'b0;
            re_dly_d   = '0;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            ptr_d      = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            ptr_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            tx_q       <= '0;
            re_dly_q   <= '0;
            rw_q       <= 1'b0;
            ack_q      <= 1'b0;
            wr_full_q  <= 1'b0;
            sda_oe_q   <= 1'b0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            tx_q       <= tx_d;
            re_dly_q   <= re_dly_d;
            rw_q       <= rw_d;
            ack_q      <= ack_d;
            wr_full_q  <= wr_full_d;
            sda_oe_q   <= sda_oe_d;
            we_q       <= we_d;
            re_q       <= re_d;
            busy_q     <= busy_d;
        end
    end

    assign sda_oe_o    = sda_oe_q;
    assign reg_addr_o  = addr_q;
    assign reg_wdata_o = wdata_q;
    assign reg_we_o    = we_q;
    assign reg_re_o    = re_q;
    assign busy_o      = busy_q;

endmodule
